// File: rtl/control_multi.sv
// Multi-cycle instruction sequencer for a MIPS-style datapath.
// Walks each instruction through fetch, decode and execute phases and drives
// the datapath enables and mux selects. It stalls on memory and on the
// multiplier, and a watchdog on the multiply wait forces a sticky trap.
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | read instruction memory; PC+4 and IR load when mem_ready
// DECODE  | register read, branch-target add, opcode dispatch
// MEMADR  | base + offset address for LW/SW
// MEMRD   | data memory read, held until mem_ready
// MEMWB   | load data written to rt
// MEMWR   | data memory write, held until mem_ready
// EXEC    | R-type ALU operation
// RWB     | R-type result written to rd
// BRANCH  | BEQ compare and conditional PC update
// JUMP    | unconditional PC load from jump target
// ADDI_EX | ADDIU ALU operation with immediate
// ADDI_WB | ADDIU result written to rt
// JAL     | link register write plus jump
// MULT    | pulse MultStart, wait for mult_done with timeout
// TRAP    | illegal opcode or multiplier timeout, held until reset
module control_multi #(
    parameter int OPW          = 6,
    parameter bit ENABLE_MULTU = 1'b1,
    parameter int MULT_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    input  logic           mult_done,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic           MultStart,
    output logic           Illegal,
    output logic [1:0]     RegDst,
    output logic [1:0]     MemtoReg,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSource,
    output logic [3:0]     state
);

    // Counter must be able to hold MULT_TIMEOUT itself.
    localparam int CW = $clog2(MULT_TIMEOUT + 1);

    // Last counter value seen in MULT before the watchdog fires; MULT is
    // therefore occupied for at most MULT_TIMEOUT cycles.
    localparam logic [CW-1:0] WAIT_LAST = CW'(MULT_TIMEOUT - 1);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
    localparam logic [OPW-1:0] OP_J     = OPW'(2);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(3);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDIU = OPW'(9);
    localparam logic [OPW-1:0] OP_MULTU = OPW'(25);
    localparam logic [OPW-1:0] OP_LW    = OPW'(35);
    localparam logic [OPW-1:0] OP_SW    = OPW'(43);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JAL     = 4'd12,
        S_MULT    = 4'd13,
        S_TRAP    = 4'd14
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    // Raw decoded controls before reset gating.
    logic            pc_write_c, pc_write_cond_c, iord_c, mem_read_c;
    logic            mem_write_c, ir_write_c, reg_write_c, alu_src_a_c;
    logic            mult_start_c, illegal_c;
    logic [1:0]      reg_dst_c, memto_reg_c, alu_src_b_c, alu_op_c, pc_source_c;

    // Next-state and multiply wait counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_ADDIU) begin
                    state_d = S_ADDI_EX;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_JAL) begin
                    state_d = S_JAL;
                end else if ((opcode == OP_MULTU) && ENABLE_MULTU) begin
                    state_d    = S_MULT;
                    wait_cnt_d = '0;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEMADR: begin
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC:    state_d = S_RWB;
            S_RWB:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = S_FETCH;
            S_JAL:     state_d = S_FETCH;
            S_MULT: begin
                wait_cnt_d = wait_cnt_q + CW'(1);
                // A result arriving on the last allowed cycle still wins.
                if (mult_done) begin
                    state_d = S_FETCH;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end
            end
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    // Datapath controls decoded from the registered state.
    always_comb begin
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        iord_c          = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        mult_start_c    = 1'b0;
        illegal_c       = 1'b0;
        reg_dst_c       = 2'b00;
        memto_reg_c     = 2'b00;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;
        pc_source_c     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
            end
            S_MEMWB: begin
                memto_reg_c = 2'b01;
                reg_write_c = 1'b1;
            end
            S_MEMWR: begin
                iord_c      = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
            end
            S_RWB: begin
                reg_dst_c   = 2'b01;
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 2'b01;
            end
            S_ADDI_EX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write_c = 1'b1;
            end
            S_JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
            end
            S_JAL: begin
                reg_dst_c   = 2'b10;
                memto_reg_c = 2'b10;
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
            end
            S_MULT: begin
                // Counter is cleared on entry, so zero marks the first cycle.
                mult_start_c = (wait_cnt_q == '0);
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Gate every control with rst so nothing is driven while reset is low,
    // including the FETCH defaults that would otherwise appear immediately.
    assign PCWrite     = rst & pc_write_c;
    assign PCWriteCond = rst & pc_write_cond_c;
    assign IorD        = rst & iord_c;
    assign MemRead     = rst & mem_read_c;
    assign MemWrite    = rst & mem_write_c;
    assign IRWrite     = rst & ir_write_c;
    assign RegWrite    = rst & reg_write_c;
    assign ALUSrcA     = rst & alu_src_a_c;
    assign MultStart   = rst & mult_start_c;
    assign Illegal     = rst & illegal_c;
    assign RegDst      = {2{rst}} & reg_dst_c;
    assign MemtoReg    = {2{rst}} & memto_reg_c;
    assign ALUSrcB     = {2{rst}} & alu_src_b_c;
    assign ALUOp       = {2{rst}} & alu_op_c;
    assign PCSource    = {2{rst}} & pc_source_c;
    assign state       = state_q;

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_control_multi.sv
// Scoreboard bench for control_multi: stimulus pushes the expected state and
// control word for each cycle, a negedge monitor pops and compares.
module tb_control_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mult_done;

    always #5 clk = ~clk;

    // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
    //                RegWrite,ALUSrcA,MultStart,Illegal,
    //                RegDst,MemtoReg,ALUSrcB,ALUOp,PCSource}
    localparam logic [19:0] C_ZERO   = 20'b0;
    localparam logic [19:0] C_F0     = {10'b0001000000, 10'b00_00_01_00_00};
    localparam logic [19:0] C_F1     = {10'b1001010000, 10'b00_00_01_00_00};
    localparam logic [19:0] C_DEC    = {10'b0000000000, 10'b00_00_11_00_00};
    localparam logic [19:0] C_MEMADR = {10'b0000000100, 10'b00_00_10_00_00};
    localparam logic [19:0] C_MEMRD  = {10'b0011000000, 10'b00_00_00_00_00};
    localparam logic [19:0] C_MEMWB  = {10'b0000001000, 10'b00_01_00_00_00};
    localparam logic [19:0] C_MEMWR  = {10'b0010100000, 10'b00_00_00_00_00};
    localparam logic [19:0] C_EXEC   = {10'b0000000100, 10'b00_00_00_10_00};
    localparam logic [19:0] C_RWB    = {10'b0000001000, 10'b01_00_00_00_00};
    localparam logic [19:0] C_BRANCH = {10'b0100000100, 10'b00_00_00_01_01};
    localparam logic [19:0] C_JUMP   = {10'b1000000000, 10'b00_00_00_00_10};
    localparam logic [19:0] C_JAL    = {10'b1000001000, 10'b10_10_00_00_10};
    localparam logic [19:0] C_ADDIWB = {10'b0000001000, 10'b00_00_00_00_00};
    localparam logic [19:0] C_MS     = {10'b0000000010, 10'b00_00_00_00_00};
    localparam logic [19:0] C_TRAP   = {10'b0000000001, 10'b00_00_00_00_00};

    // Default-parameter instance.
    logic       pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, rw_a, asa_a, ms_a, ill_a;
    logic [1:0] rd_a, mtr_a, asb_a, aop_a, pcs_a;
    logic [3:0] state_a;
    logic [19:0] ctrl_a;

    // Short-timeout instance.
    logic       pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, rw_b, asa_b, ms_b, ill_b;
    logic [1:0] rd_b, mtr_b, asb_b, aop_b, pcs_b;
    logic [3:0] state_b;
    logic [19:0] ctrl_b;

    control_multi u_dut (
        .clk(clk), .rst(rst_n), .opcode(opcode), .mem_ready(mem_ready), .mult_done(mult_done),
        .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IorD(iord_a), .MemRead(mrd_a),
        .MemWrite(mwr_a), .IRWrite(irw_a), .RegWrite(rw_a), .ALUSrcA(asa_a),
        .MultStart(ms_a), .Illegal(ill_a), .RegDst(rd_a), .MemtoReg(mtr_a),
        .ALUSrcB(asb_a), .ALUOp(aop_a), .PCSource(pcs_a), .state(state_a)
    );

    control_multi #(.MULT_TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst(rst_n), .opcode(opcode), .mem_ready(mem_ready), .mult_done(mult_done),
        .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b), .MemRead(mrd_b),
        .MemWrite(mwr_b), .IRWrite(irw_b), .RegWrite(rw_b), .ALUSrcA(asa_b),
        .MultStart(ms_b), .Illegal(ill_b), .RegDst(rd_b), .MemtoReg(mtr_b),
        .ALUSrcB(asb_b), .ALUOp(aop_b), .PCSource(pcs_b), .state(state_b)
    );

    assign ctrl_a = {pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, rw_a, asa_a, ms_a, ill_a,
                     rd_a, mtr_a, asb_a, aop_a, pcs_a};
    assign ctrl_b = {pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, rw_b, asa_b, ms_b, ill_b,
                     rd_b, mtr_b, asb_b, aop_b, pcs_b};

    typedef struct {
        bit          sel;
        logic [3:0]  st;
        logic [19:0] ctrl;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // One cycle of stimulus: drive inputs just after the edge, queue what the
    // selected instance must show for the rest of this cycle.
    task automatic step(input logic r, input bit sel, input string nm, input logic [3:0] st,
                        input logic [19:0] c, input logic mr, input logic md, input logic [5:0] op);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        mem_ready = mr;
        mult_done = md;
        opcode    = op;
        e.sel  = sel;
        e.st   = st;
        e.ctrl = c;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input bit sel);
        step(1'b0, sel, "rst_a", 4'd0, C_ZERO, 1'b1, 1'b0, 6'd0);
        step(1'b0, sel, "rst_b", 4'd0, C_ZERO, 1'b1, 1'b0, 6'd0);
    endtask

    // Monitor: compare whatever the stimulus queued for this cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0]  act_st;
        logic [19:0] act_c;
        if (exp_q.size() != 0) begin
            e      = exp_q.pop_front();
            act_st = e.sel ? state_b : state_a;
            act_c  = e.sel ? ctrl_b : ctrl_a;
            checks++;
            if (act_st !== e.st) begin
                errors++;
                $display("FAIL %s state: got %0d expected %0d", e.name, act_st, e.st);
            end
            checks++;
            if (act_c !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl: got %b expected %b", e.name, act_c, e.ctrl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        mult_done = 1'b0;
        opcode    = 6'd0;
        do_reset(1'b0);

        // R-type: 0,1,6,7
        step(1, 0, "r_fetch", 4'd0, C_F1,   1, 0, 6'd0);
        step(1, 0, "r_dec",   4'd1, C_DEC,  1, 0, 6'd0);
        step(1, 0, "r_exec",  4'd6, C_EXEC, 1, 0, 6'd0);
        step(1, 0, "r_wb",    4'd7, C_RWB,  1, 0, 6'd0);

        // LW with three memory wait cycles in MEMRD
        step(1, 0, "lw_fetch", 4'd0, C_F1,     1, 0, 6'd35);
        step(1, 0, "lw_dec",   4'd1, C_DEC,    1, 0, 6'd35);
        step(1, 0, "lw_adr",   4'd2, C_MEMADR, 1, 0, 6'd35);
        step(1, 0, "lw_rd0",   4'd3, C_MEMRD,  0, 0, 6'd35);
        step(1, 0, "lw_rd1",   4'd3, C_MEMRD,  0, 0, 6'd35);
        step(1, 0, "lw_rd2",   4'd3, C_MEMRD,  0, 0, 6'd35);
        step(1, 0, "lw_rd3",   4'd3, C_MEMRD,  1, 0, 6'd35);
        step(1, 0, "lw_wb",    4'd4, C_MEMWB,  1, 0, 6'd35);

        // SW
        step(1, 0, "sw_fetch", 4'd0, C_F1,     1, 0, 6'd43);
        step(1, 0, "sw_dec",   4'd1, C_DEC,    1, 0, 6'd43);
        step(1, 0, "sw_adr",   4'd2, C_MEMADR, 1, 0, 6'd43);
        step(1, 0, "sw_wr",    4'd5, C_MEMWR,  1, 0, 6'd43);

        // BEQ, J, JAL
        step(1, 0, "beq_fetch", 4'd0,  C_F1,     1, 0, 6'd4);
        step(1, 0, "beq_dec",   4'd1,  C_DEC,    1, 0, 6'd4);
        step(1, 0, "beq",       4'd8,  C_BRANCH, 1, 0, 6'd4);
        step(1, 0, "j_fetch",   4'd0,  C_F1,     1, 0, 6'd2);
        step(1, 0, "j_dec",     4'd1,  C_DEC,    1, 0, 6'd2);
        step(1, 0, "j",         4'd9,  C_JUMP,   1, 0, 6'd2);
        step(1, 0, "jal_fetch", 4'd0,  C_F1,     1, 0, 6'd3);
        step(1, 0, "jal_dec",   4'd1,  C_DEC,    1, 0, 6'd3);
        step(1, 0, "jal",       4'd12, C_JAL,    1, 0, 6'd3);

        // ADDIU
        step(1, 0, "addi_fetch", 4'd0,  C_F1,     1, 0, 6'd9);
        step(1, 0, "addi_dec",   4'd1,  C_DEC,    1, 0, 6'd9);
        step(1, 0, "addi_ex",    4'd10, C_MEMADR, 1, 0, 6'd9);
        step(1, 0, "addi_wb",    4'd11, C_ADDIWB, 1, 0, 6'd9);

        // Fetch stall, then MULTU with mult_done in the fifth MULT cycle
        step(1, 0, "mu_fwait0", 4'd0,  C_F0,   0, 0, 6'd25);
        step(1, 0, "mu_fwait1", 4'd0,  C_F0,   0, 0, 6'd25);
        step(1, 0, "mu_fetch",  4'd0,  C_F1,   1, 0, 6'd25);
        step(1, 0, "mu_dec",    4'd1,  C_DEC,  1, 0, 6'd25);
        step(1, 0, "mu_m0",     4'd13, C_MS,   1, 0, 6'd25);
        step(1, 0, "mu_m1",     4'd13, C_ZERO, 1, 0, 6'd25);
        step(1, 0, "mu_m2",     4'd13, C_ZERO, 1, 0, 6'd25);
        step(1, 0, "mu_m3",     4'd13, C_ZERO, 1, 0, 6'd25);
        step(1, 0, "mu_m4",     4'd13, C_ZERO, 1, 1, 6'd25);
        step(1, 0, "mu_back",   4'd0,  C_F0,   0, 0, 6'd63);

        // Illegal opcode 63, trap is sticky
        step(1, 0, "il_fetch",  4'd0,  C_F1,   1, 0, 6'd63);
        step(1, 0, "il_dec",    4'd1,  C_DEC,  1, 0, 6'd63);
        step(1, 0, "il_trap",   4'd14, C_TRAP, 1, 1, 6'd0);
        step(1, 0, "il_stick0", 4'd14, C_TRAP, 1, 0, 6'd0);
        step(1, 0, "il_stick1", 4'd14, C_TRAP, 1, 0, 6'd35);

        // Async reset in the middle of a stalled MEMWR
        do_reset(1'b0);
        step(1, 0, "swr_fetch", 4'd0, C_F1,     1, 0, 6'd43);
        step(1, 0, "swr_dec",   4'd1, C_DEC,    1, 0, 6'd43);
        step(1, 0, "swr_adr",   4'd2, C_MEMADR, 1, 0, 6'd43);
        step(1, 0, "swr_wr",    4'd5, C_MEMWR,  0, 0, 6'd43);
        step(0, 0, "swr_rst0",  4'd0, C_ZERO,   1, 0, 6'd43);
        step(0, 0, "swr_rst1",  4'd0, C_ZERO,   1, 0, 6'd0);
        step(1, 0, "swr_rest",  4'd0, C_F1,     1, 0, 6'd0);
        step(1, 0, "swr_rdec",  4'd1, C_DEC,    1, 0, 6'd0);

        // Short timeout instance: MULTU with no mult_done traps after 4 cycles
        do_reset(1'b1);
        step(1, 1, "t4_fetch", 4'd0,  C_F1,   1, 0, 6'd25);
        step(1, 1, "t4_dec",   4'd1,  C_DEC,  1, 0, 6'd25);
        step(1, 1, "t4_m0",    4'd13, C_MS,   1, 0, 6'd25);
        step(1, 1, "t4_m1",    4'd13, C_ZERO, 1, 0, 6'd25);
        step(1, 1, "t4_m2",    4'd13, C_ZERO, 1, 0, 6'd25);
        step(1, 1, "t4_m3",    4'd13, C_ZERO, 1, 0, 6'd25);
        step(1, 1, "t4_trap",  4'd14, C_TRAP, 1, 1, 6'd25);
        step(1, 1, "t4_hold0", 4'd14, C_TRAP, 1, 1, 6'd0);
        step(1, 1, "t4_hold1", 4'd14, C_TRAP, 1, 0, 6'd0);
        do_reset(1'b1);

        // mult_done on the last allowed cycle beats the timeout
        step(1, 1, "tp_fetch", 4'd0,  C_F1,   1, 0, 6'd25);
        step(1, 1, "tp_dec",   4'd1,  C_DEC,  1, 0, 6'd25);
        step(1, 1, "tp_m0",    4'd13, C_MS,   1, 0, 6'd25);
        step(1, 1, "tp_m1",    4'd13, C_ZERO, 1, 0, 6'd25);
        step(1, 1, "tp_m2",    4'd13, C_ZERO, 1, 0, 6'd25);
        step(1, 1, "tp_m3",    4'd13, C_ZERO, 1, 1, 6'd25);
        step(1, 1, "tp_fetch2", 4'd0, C_F1,   1, 0, 6'd0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
